// File: rtl/wb_regfile_pkg.sv
// Shared widths and control-level constants for the register file slice.
package wb_regfile_pkg;

  localparam int unsigned RegAddrBus = 5;
  localparam int unsigned RegBus     = 32;
  localparam int unsigned RegNum     = 32;

  localparam logic [RegAddrBus-1:0] NOPRegAddr = '0;
  localparam logic [RegBus-1:0]     ZeroWord   = '0;

  localparam logic RstEnable    = 1'b1;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;
  localparam logic ReadDisable  = 1'b0;

endpackage

// File: rtl/wb_regfile_hilo.sv
// HI/LO special registers: written together from writeback, no bypass.
module hilo_reg
  import wb_regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [RegBus-1:0] hi_i,
  input  logic [RegBus-1:0] lo_i,
  output logic [RegBus-1:0] hi_o,
  output logic [RegBus-1:0] lo_o
);

  logic [RegBus-1:0] hi_q;
  logic [RegBus-1:0] lo_q;

  // Clear on reset, otherwise capture both halves on a write edge.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      hi_q <= ZeroWord;
      lo_q <= ZeroWord;
    end else if (we == WriteEnable) begin
      hi_q <= hi_i;
      lo_q <= lo_i;
    end
  end

  // Outputs read zero for the whole time reset is held, even before the first reset edge.
  always_comb begin
    hi_o = hi_q;
    lo_o = lo_q;
    if (rst == RstEnable) begin
      hi_o = ZeroWord;
      lo_o = ZeroWord;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// 32x32 general-purpose register file with two combinational read ports,
// same-cycle write-through bypass, and an attached HI/LO register pair.
module wb_regfile
  import wb_regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_wreg,
  input  logic [RegAddrBus-1:0] wb_wd,
  input  logic [RegBus-1:0]     wb_wdata,
  input  logic                  wb_whilo,
  input  logic [RegBus-1:0]     wb_hi,
  input  logic [RegBus-1:0]     wb_lo,
  input  logic                  re1,
  input  logic                  re2,
  input  logic [RegAddrBus-1:0] raddr1,
  input  logic [RegAddrBus-1:0] raddr2,
  output logic [RegBus-1:0]     rdata1,
  output logic [RegBus-1:0]     rdata2,
  output logic [RegBus-1:0]     hi_o,
  output logic [RegBus-1:0]     lo_o
);

  logic [RegBus-1:0] regs [0:RegNum-1];

  // Priority: reset, disabled port, register 0, pending write to the same register, stored value.
  function automatic logic [RegBus-1:0] read_port(
    input logic                  rst_i,
    input logic                  re,
    input logic [RegAddrBus-1:0] raddr,
    input logic                  wreg,
    input logic [RegAddrBus-1:0] wd,
    input logic [RegBus-1:0]     wdata,
    input logic [RegBus-1:0]     stored
  );
    logic [RegBus-1:0] r;
    r = ZeroWord;
    if (rst_i == RstEnable)                         r = ZeroWord;
    else if (re == ReadDisable)                     r = ZeroWord;
    else if (raddr == NOPRegAddr)                   r = ZeroWord;
    else if ((wreg == WriteEnable) && (wd == raddr)) r = wdata;
    else                                            r = stored;
    return r;
  endfunction

  // GPR array: clear everything on reset, otherwise accept writeback writes except to register 0.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      for (int unsigned i = 0; i < RegNum; i++) begin
        regs[i] <= ZeroWord;
      end
    end else if ((wb_wreg == WriteEnable) && (wb_wd != NOPRegAddr)) begin
      regs[wb_wd] <= wb_wdata;
    end
  end

  // Independent combinational read ports.
  always_comb begin
    rdata1 = read_port(rst, re1, raddr1, wb_wreg, wb_wd, wb_wdata, regs[raddr1]);
    rdata2 = read_port(rst, re2, raddr2, wb_wreg, wb_wd, wb_wdata, regs[raddr2]);
  end

  hilo_reg u_hilo (
    .clk  (clk),
    .rst  (rst),
    .we   (wb_whilo),
    .hi_i (wb_hi),
    .lo_i (wb_lo),
    .hi_o (hi_o),
    .lo_o (lo_o)
  );

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have: clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have: wb_wreg  input  1  GPR write enable from writeback stage.
REQ-004 SHALL have: wb_wd  input  5  GPR write address.
REQ-005 SHALL have: wb_wdata  input  32  GPR write data.
REQ-006 SHALL have: wb_whilo  input  1  HI/LO write enable.
REQ-007 SHALL have: wb_hi, wb_lo  input  32 each  HI/LO write data.
REQ-008 SHALL have: re1, re2  input  1 each  read-port enables from decode.
REQ-009 SHALL have: raddr1, raddr2  input  5 each  read addresses.
REQ-010 SHALL have: rdata1, rdata2  output  32 each  read data, combinational.
REQ-011 SHALL have: hi_o, lo_o  output  32 each  current HI/LO, registered.

Function
REQ-012 SHALL hold 32 GPRs x 32 bits plus one HI and one LO register.
REQ-013 On rising edge with rst=0, wb_wreg=1 and wb_wd!=0: GPR[wb_wd] <= wb_wdata.
REQ-014 Writes to GPR 0 SHALL be discarded; GPR 0 SHALL always read 0.
REQ-015 On rising edge with rst=0 and wb_whilo=1: HI <= wb_hi and LO <= wb_lo in the same edge.
REQ-016 wb_whilo=0 SHALL leave HI/LO unchanged; hi_o/lo_o SHALL show new values the cycle after the write edge (no bypass).
REQ-017 Each read port, evaluated in priority order: rst=1 -> 0; re=0 -> 0; raddr=0 -> 0; re=1, wb_wreg=1, wb_wd==raddr -> wb_wdata (same-cycle write-through bypass); else GPR[raddr].
REQ-018 Both read ports SHALL be independent; same address on both SHALL return identical data, including the bypass case.
REQ-019 Write latency SHALL be one edge; read latency SHALL be zero cycles (combinational).
REQ-020 wb_wreg=1 with wb_wd=0 SHALL not trigger the bypass; the read returns 0.
REQ-021 Simultaneous GPR and HI/LO writes in one cycle SHALL both take effect.
REQ-022 No stall input; stalling and bubble insertion SHALL be handled upstream, and a bubble (wb_wreg=0, wb_whilo=0) SHALL cause no state change.

Reset
REQ-023 On a rising edge with rst=1, all 32 GPRs, HI and LO SHALL clear to 0; any write presented in that cycle SHALL be dropped.
REQ-024 While rst=1, rdata1, rdata2, hi_o and lo_o SHALL read 0.
REQ-025 Reset asserted mid-operation SHALL discard all prior contents; the first write after deassertion SHALL behave per REQ-013/015.

Structure
REQ-026 Widths RegAddrBus (5), RegBus (32), RegNum (32), NOPRegAddr, ZeroWord, RstEnable, WriteEnable, WriteDisable, ReadEnable and ReadDisable SHALL come from the shared defines package; none SHALL be redeclared locally.
REQ-027 HI/LO storage SHALL be a sub-module hilo_reg (clk, rst, we, hi_i, lo_i, hi_o, lo_o) instantiated once; GPR array and read muxes SHALL stay in wb_regfile.

Verification
REQ-028 Reset, then read all 32 addresses on both ports with re=1 -> all return 0x00000000; hi_o=lo_o=0.
REQ-029 Write 0xDEADBEEF to reg 5; next cycle raddr1=5, re1=1 -> rdata1=0xDEADBEEF. Write 0x12345678 to reg 0 -> raddr2=0 returns 0.
REQ-030 Same cycle: wb_wreg=1, wb_wd=7, wb_wdata=0xA5A5A5A5, raddr1=raddr2=7, re1=re2=1 -> both rdata=0xA5A5A5A5 before the edge; re2=0 -> rdata2=0.
REQ-031 wb_whilo=1, wb_hi=0x11112222, wb_lo=0x33334444 -> hi_o/lo_o still old values that cycle, 0x11112222/0x33334444 next cycle; concurrent wb_wreg write to reg 3 also lands.
REQ-032 Fill regs 1-31 with their index, assert rst one cycle while wb_wreg=1 to reg 9 with 0xFFFFFFFF -> afterwards all regs and HI/LO read 0, reg 9 included.
REQ-033 Random write/read stream over 10,000 cycles checked against a reference model including bypass, reg-0 and re=0 rules -> zero mismatches.
